module_keypad_scan_param: RTL and testbench

- Parametrised matrix-keypad scanner: drives rows, samples columns, debounces, emits one key code per press over a valid/ready handshake.
- Successor to the fixed 4x4 scanner in module_top_general; the 7-seg/display path consumes key_code.
- Adds generic ROWS/COLS, frame-based debounce, multi-key priority, output handshake, overrun flag.

---
 rtl/module_keypad_scan_param.sv | 234 +++++++++++++++++++++++
 tb/tb_module_keypad_scan_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_keypad_scan_param.sv
// module_keypad_scan_param
// Parametrised matrix-keypad scanner. One row is driven low per slot of
// SCAN_DIV cycles; columns are sampled at the end of each slot. The first
// closed key in scan order (lowest row, then lowest column) is the frame
// result. A once-per-frame FSM debounces press and release, and each
// debounced press is offered on a valid/ready handshake. An event that
// arrives while an earlier one is still undelivered is dropped and the
// sticky overrun flag is set.
// Optional build macro: KEYPAD_REPEAT_EN. When it is defined, a held key
// re-emits every REPEAT_FRAMES frames.
module module_keypad_scan_param #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 5000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 50
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COLS-1:0]                 column,
    output logic [ROWS-1:0]                 row,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic                            key_held,
    output logic                            overrun,
    input  logic                            overrun_clr
);

    localparam int unsigned CW    = $clog2(ROWS * COLS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CLW   = $clog2(COLS);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // Scan timing and per-frame accumulation
    logic [DIV_W-1:0] div_cnt_q;
    logic [RW-1:0]    row_idx_q;
    logic [RW-1:0]    row_idx_d;
    logic [ROWS-1:0]  row_q;
    logic             found_q;
    logic [CW-1:0]    acc_code_q;

    // Debounce FSM
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CW-1:0]    cand_q;
    logic             held_q;
    logic             emit_q;
    logic [CW-1:0]    emit_code_q;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);
    logic [REP_W-1:0] rep_cnt_q;
`endif

    // Output handshake
    logic [CW-1:0]    key_code_q;
    logic             key_valid_q;
    logic             overrun_q;

    // Combinational helpers
    logic             slot_end;
    logic             last_row;
    logic             frame_end;
    logic             any_hit;
    logic [CLW-1:0]   first_col;
    logic [CW-1:0]    slot_code;
    logic             frame_hit;
    logic [CW-1:0]    frame_code;
    logic             accept;

    assign slot_end  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign last_row  = (row_idx_q == RW'(ROWS - 1));
    assign frame_end = slot_end && last_row;
    assign row_idx_d = last_row ? '0 : row_idx_q + RW'(1);
    assign accept    = key_valid_q && key_ready;

    // Lowest-numbered closed column on the currently driven row
    always_comb begin
        logic hit_seen;
        hit_seen  = 1'b0;
        first_col = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!column[i] && !hit_seen) begin
                first_col = CLW'(i);
                hit_seen  = 1'b1;
            end
        end
        any_hit = hit_seen;
    end

    // An earlier row's hit in this frame outranks the current row's hit
    assign slot_code  = CW'(row_idx_q) * CW'(COLS) + CW'(first_col);
    assign frame_hit  = found_q || any_hit;
    assign frame_code = found_q ? acc_code_q : slot_code;

    // Slot divider, row rotation and first-hit capture within a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            row_idx_q  <= '0;
            row_q      <= ~ROWS'(1);
            found_q    <= 1'b0;
            acc_code_q <= '0;
        end else if (slot_end) begin
            div_cnt_q <= '0;
            row_idx_q <= row_idx_d;
            row_q     <= ~(ROWS'(1) << row_idx_d);
            if (last_row) begin
                found_q <= 1'b0;
            end else if (!found_q && any_hit) begin
                found_q    <= 1'b1;
                acc_code_q <= slot_code;
            end
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Press/release debounce, evaluated once per frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            held_q      <= 1'b0;
            emit_q      <= 1'b0;
            emit_code_q <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            emit_q <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_hit) begin
                            state_q <= ST_CHECK;
                            cand_q  <= frame_code;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (!frame_hit) begin
                            state_q <= ST_IDLE;
                        end else if (frame_code != cand_q) begin
                            cand_q <= frame_code;
                            cnt_q  <= CNT_W'(1);
                        end else if (cnt_q == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                            state_q     <= ST_PRESSED;
                            held_q      <= 1'b1;
                            emit_q      <= 1'b1;
                            emit_code_q <= cand_q;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (!frame_hit) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_q <= '0;
                        end else if (rep_cnt_q == REP_W'(REPEAT_FRAMES - 1)) begin
                            rep_cnt_q   <= '0;
                            emit_q      <= 1'b1;
                            emit_code_q <= cand_q;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + REP_W'(1);
`endif
                        end
                    end
                    ST_RELEASE: begin
                        if (frame_hit) begin
                            state_q <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_q <= '0;
`endif
                        end else if (cnt_q == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                            state_q <= ST_IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Event delivery: load when the slot is free or being drained, else drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
            if (emit_q) begin
                if (!key_valid_q || accept) begin
                    key_code_q  <= emit_code_q;
                    key_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_module_keypad_scan_param.sv
// Testbench for module_keypad_scan_param: keypad matrix model, frame-level
// reference model of debounce/priority/handshake, and a scoreboard monitor.
module tb_module_keypad_scan_param;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int REP   = 2;
    localparam int FRAME = ROWS * SDIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    logic [15:0] keys = '0;

    int n_vec = 0;
    int n_bad = 0;
    int xfer_count = 0;
    int ready_mode = 1;
    bit clr_req = 0;

    // reference model state
    int hist[$];
    int exp_q[$];
    bit m_held = 0;
    int m_cand = 0;
    int m_rep = 0;
    bit exp_ov = 0;

    always #5 clk = ~clk;

    module_keypad_scan_param #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SDIV),
        .DEBOUNCE_FRAMES(DEB),
        .REPEAT_FRAMES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .column(column),
        .row(row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held(key_held),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    // keypad matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        column = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && !row[r]) column[c] = 1'b0;
    end

    // key_ready driver: 0 = hold low, 1 = hold high, 2 = random, high every 8th cycle
    initial begin
        int unsigned rc;
        rc = 0;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            case (ready_mode)
                0: key_ready = 1'b0;
                1: key_ready = 1'b1;
                default: key_ready = (rc % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_result(input logic [15:0] k);
        for (int i = 0; i < 16; i++)
            if (k[i]) return i;
        return -1;
    endfunction

    task automatic emit(input int code);
        if (exp_q.size() != 0) exp_ov = 1;
        else exp_q.push_back(code);
    endtask

    // one frame of the reference model, in terms of the history of frame results
    task automatic model_frame(input logic [15:0] k);
        int res, run;
`ifdef KEYPAD_REPEAT_EN
        int prev;
        prev = (hist.size() != 0) ? hist[$] : -1;
`endif
        res = frame_result(k);
        hist.push_back(res);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != res) break;
            run++;
        end
        if (!m_held) begin
            if (res >= 0 && run == DEB) begin
                m_held = 1;
                m_cand = res;
                m_rep  = 0;
                emit(res);
            end
        end else if (res < 0) begin
            if (run == DEB) m_held = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
            if (prev < 0) m_rep = 0;
            else begin
                m_rep++;
                if (m_rep == REP) begin
                    m_rep = 0;
                    emit(m_cand);
                end
            end
`endif
        end
    endtask

    // apply one frame of keys; check flags resulting from the previous frame
    task automatic run_frame(input logic [15:0] k);
        keys = k;
        repeat (2) @(negedge clk);
        check("key_held", key_held, m_held);
        check("overrun", overrun, exp_ov);
        if (clr_req) begin
            overrun_clr = 1'b1;
            @(negedge clk);
            overrun_clr = 1'b0;
            exp_ov  = 0;
            clr_req = 0;
            repeat (FRAME - 3) @(negedge clk);
        end else begin
            repeat (FRAME - 2) @(negedge clk);
        end
        model_frame(k);
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keys = '0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_held", key_held, 0);
        check("rst_overrun", overrun, 0);
        exp_q.delete();
        hist.delete();
        m_held = 0;
        m_rep  = 0;
        exp_ov = 0;
        rst = 1'b0;
    endtask

    // scoreboard monitor
    initial begin
        bit pv, px;
        logic [3:0] pc;
        int e;
        pv = 0; px = 0; pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0; px = 0;
            end else begin
                if (px) check("valid_after_accept", key_valid, 0);
                if (pv && !px) check("code_stable", key_code, pc);
                px = key_valid && key_ready;
                if (px) begin
                    xfer_count++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_event: got code %0d, required no event (t=%0t)", key_code, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_code", key_code, e);
                    end
                end
                pv = key_valid;
                pc = key_code;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int x0, sel, n;
        logic [15:0] pat;
        logic [3:0] er;

        // reset and scan order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            er = ~(4'b0001 << (i % 4));
            check("scan_row", row, er);
            repeat (SDIV) @(negedge clk);
        end
        model_frame('0);
        model_frame('0);

        // single press r2c1 -> code 9
        ready_mode = 1;
        x0 = xfer_count;
        run_frames(16'h0200, 6);
        run_frames('0, 4);
        check("single_event_count", xfer_count - x0, 1);

        // bounce: no event
        x0 = xfer_count;
        run_frame(16'h0200);
        run_frame('0);
        run_frames(16'h0200, 2);
        run_frames('0, 2);
        check("bounce_event_count", xfer_count - x0, 0);

        // multi-key r1c3 + r3c0 -> code 7
        x0 = xfer_count;
        run_frames(16'h1080, 4);
        run_frames('0, 4);
        check("multi_event_count", xfer_count - x0, 1);

        // backpressure and overrun
        ready_mode = 0;
        x0 = xfer_count;
        run_frames(16'h0020, 4);
        run_frames('0, 3);
        run_frames(16'h0400, 4);
        check("bp_key_code", key_code, 5);
        check("bp_key_valid", key_valid, 1);
        check("bp_overrun", overrun, 1);
        ready_mode = 1;
        run_frames('0, 3);
        check("bp_event_count", xfer_count - x0, 1);
        clr_req = 1;
        run_frame('0);
        run_frame('0);

        // hold code 0 for 9 frames
        x0 = xfer_count;
        run_frames(16'h0001, 9);
        run_frames('0, 4);
`ifdef KEYPAD_REPEAT_EN
        check("repeat_event_count", xfer_count - x0, 4);
`else
        check("repeat_event_count", xfer_count - x0, 1);
`endif

        // reset in the middle of a debounce discards the candidate
        run_frames(16'h0008, 2);
        do_reset();
        x0 = xfer_count;
        run_frames(16'h0008, 2);
        check("mid_reset_no_event", xfer_count - x0, 0);
        run_frames(16'h0008, 2);
        run_frames('0, 4);
        check("mid_reset_event_count", xfer_count - x0, 1);

        // randomized key patterns with random backpressure
        ready_mode = 2;
        pat = '0;
        for (int g = 0; g < 40; g++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) pat = '0;
            else if (sel <= 7) pat = 16'(1) << $urandom_range(0, 15);
            else if (sel == 8) pat = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            n = $urandom_range(1, 5);
            run_frames(pat, n);
        end
        run_frames('0, 4);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
